randn_seq_ctrl: RTL

//  Sequencing controller for one imitator noise generator (randn, 10-bit signed sum-of-4-uniform output).

---
 rtl/randn_seq_if.sv | 38 +++
 rtl/randn_seq_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/randn_seq_if.sv
// randn_seq_if
//   Bundles the control, generator and noise-stream signals that pass between
//   the noise sequencing controller and its surroundings.
//   slave  : the controller side (randn_seq_ctrl)
//   master : the side that drives start/stop/config and the generator sample
//            and consumes the noise stream
//
//   Stream handshake: noise_vld qualifies noise_out in the same cycle. There
//   is no ready/backpressure; the consumer (signal adder) must take every
//   sample on the cycle noise_vld is high. When noise_vld is low, noise_out
//   holds its last value and must be ignored.
interface randn_seq_if #(
  parameter int IN_W  = 10,
  parameter int AMP_W = 8,
  parameter int OUT_W = 12,
  parameter int LEN_W = 16
) ();
  logic             start;
  logic             stop;
  logic [AMP_W-1:0] amp;
  logic [LEN_W-1:0] burst_len;
  logic             gen_rst_n;
  logic [IN_W-1:0]  gen_sample;
  logic [OUT_W-1:0] noise_out;
  logic             noise_vld;
  logic             busy;
  logic             done;

  modport master (
    output start, stop, amp, burst_len, gen_sample,
    input  gen_rst_n, noise_out, noise_vld, busy, done
  );

  modport slave (
    input  start, stop, amp, burst_len, gen_sample,
    output gen_rst_n, noise_out, noise_vld, busy, done
  );
endinterface

// File: rtl/randn_seq_ctrl.sv
// randn_seq_ctrl
//   Sequencing controller for one randn noise generator. Holds the generator
//   in reset while idle, releases it on start, discards the warm-up transient,
//   then scales each sample by a latched amplitude (gain = amp / 2^AMP_SHIFT)
//   with saturation and emits a valid-qualified stream, either continuous
//   (burst_len == 0) or a fixed-length burst.
// Ports
//   clk         : system clock
//   reset       : synchronous, active-high reset
//   bus         : randn_seq_if slave modport (start/stop/amp/burst_len in,
//                 gen_rst_n out, gen_sample in, noise_out/noise_vld/busy/done out)
//   o_dbg_state : current FSM state (0 IDLE, 1 WARMUP, 2 RUN)
module randn_seq_ctrl #(
  parameter int IN_W       = 10,
  parameter int AMP_W      = 8,
  parameter int AMP_SHIFT  = 4,
  parameter int OUT_W      = 12,
  parameter int LEN_W      = 16,
  parameter int WARMUP_CYC = 5
) (
  input  logic        clk,
  input  logic        reset,
  randn_seq_if.slave  bus,
  output logic [1:0]  o_dbg_state
);

  localparam int PROD_W = IN_W + AMP_W + 1;
  localparam int HI_W   = PROD_W - OUT_W + 1;
  localparam int WCNT_W = $clog2(WARMUP_CYC + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WARMUP_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_gen_rst_n;
  logic [OUT_W-1:0]   r_noise_out;
  logic               r_noise_vld;
  logic               r_busy;
  logic               r_done;
  logic [WCNT_W-1:0]  r_wcnt;
  logic [LEN_W-1:0]   r_scnt;
  logic [AMP_W-1:0]   r_amp;
  logic [LEN_W-1:0]   r_burst_len;

  logic signed [PROD_W-1:0] w_samp_x;
  logic signed [PROD_W-1:0] w_amp_x;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] w_shift;
  logic        [HI_W-1:0]   w_hi;
  logic        [OUT_W-1:0]  w_sat;
  logic                     w_burst_end;

  // Both operands are widened to the full product width so the signed
  // multiply is exact; amp is zero-extended, i.e. always non-negative.
  always_comb begin
    w_samp_x = {{(AMP_W + 1){bus.gen_sample[IN_W-1]}}, bus.gen_sample};
    w_amp_x  = {{IN_W{1'b0}}, 1'b0, r_amp};
    w_prod   = w_samp_x * w_amp_x;
    w_shift  = w_prod >>> AMP_SHIFT;
    // The value fits in OUT_W bits only when every bit from the OUT_W sign
    // position upward is a copy of the sign.
    w_hi     = w_shift[PROD_W-1:OUT_W-1];
    if ((w_hi == '0) || (w_hi == '1)) begin
      w_sat = w_shift[OUT_W-1:0];
    end else if (w_shift[PROD_W-1]) begin
      w_sat = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      w_sat = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  // scnt already counts the samples emitted so far, so equality means the
  // last burst sample went out on the previous edge.
  assign w_burst_end = (r_burst_len != '0) && (r_scnt == r_burst_len);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_gen_rst_n <= 1'b0;
      r_noise_out <= '0;
      r_noise_vld <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wcnt      <= '0;
      r_scnt      <= '0;
      r_amp       <= '0;
      r_burst_len <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_gen_rst_n <= 1'b0;
          r_noise_vld <= 1'b0;
          // stop is not looked at here, so start wins when both are high.
          if (bus.start) begin
            r_amp       <= bus.amp;
            r_burst_len <= bus.burst_len;
            r_wcnt      <= '0;
            r_scnt      <= '0;
            r_gen_rst_n <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_WARMUP;
          end
        end
        S_WARMUP: begin
          if (bus.stop) begin
            r_gen_rst_n <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
            if (r_wcnt == WCNT_LAST) begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          // stop is checked first so that stop and burst completion in the
          // same cycle produce a single done pulse.
          if (bus.stop || w_burst_end) begin
            r_noise_vld <= 1'b0;
            r_gen_rst_n <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_noise_out <= w_sat;
            r_noise_vld <= 1'b1;
            // Saturating count: continuous runs never wrap back to a value
            // that could look like a burst end.
            if (r_scnt != '1) begin
              r_scnt <= r_scnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gen_rst_n = r_gen_rst_n;
  assign bus.noise_out = r_noise_out;
  assign bus.noise_vld = r_noise_vld;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign o_dbg_state   = r_state;

endmodule
